// File: rtl/display_pkg.sv
// Shared constants and state encoding for the two-digit display multiplexer.
package display_pkg;

    localparam int DEF_MUX_PERIOD   = 24000;
    localparam int DEF_BLANK_CYCLES = 120;

    typedef logic [1:0] mux_state_t;

    localparam mux_state_t ST_SHOW_R   = 2'd0;
    localparam mux_state_t ST_BLANK_RL = 2'd1;
    localparam mux_state_t ST_SHOW_L   = 2'd2;
    localparam mux_state_t ST_BLANK_LR = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/display_mux_ctrl_digit_history.sv
// Two-entry shift history of accepted key codes with per-entry valid flags.
module digit_history
    import display_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    input  logic       clear,
    output logic [3:0] newest,
    output logic [3:0] older,
    output logic [1:0] valid
);

    logic [3:0] newest_q, newest_d;
    logic [3:0] older_q, older_d;
    logic [1:0] valid_q, valid_d;

    // Clear wins over a simultaneous key so a stale press never survives.
    always_comb begin
        newest_d = newest_q;
        older_d  = older_q;
        valid_d  = valid_q;
        if (clear) begin
            newest_d = 4'h0;
            older_d  = 4'h0;
            valid_d  = 2'b00;
        end else if (key_valid) begin
            older_d  = newest_q;
            newest_d = key_code;
            valid_d  = {valid_q[0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            newest_q <= 4'h0;
            older_q  <= 4'h0;
            valid_q  <= 2'b00;
        end else begin
            newest_q <= newest_d;
            older_q  <= older_d;
            valid_q  <= valid_d;
        end
    end

    assign newest = newest_q;
    assign older  = older_q;
    assign valid  = valid_q;

endmodule

// File: rtl/display_mux_ctrl.sv
// Time-multiplexed two-digit display driver with dead-time between digits.
module display_mux_ctrl
    import display_pkg::*;
#(
    parameter int MUX_PERIOD   = DEF_MUX_PERIOD,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    input  logic       clear,
    output logic [3:0] digit_sel,
    output logic [1:0] an_n,
    output logic [1:0] hist_valid
);

    localparam int CW = $clog2(max_int(MUX_PERIOD, BLANK_CYCLES));
    localparam logic [CW-1:0] SHOW_LAST  = CW'(MUX_PERIOD - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    mux_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    newest, older;
    logic [1:0]    hv;

    digit_history u_hist (
        .clk       (clk),
        .rst       (rst),
        .key_code  (key_code),
        .key_valid (key_valid),
        .clear     (clear),
        .newest    (newest),
        .older     (older),
        .valid     (hv)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        case (state_q)
            ST_SHOW_R: if (cnt_q == SHOW_LAST) begin
                state_d = ST_BLANK_RL;
                cnt_d   = '0;
            end
            ST_BLANK_RL: if (cnt_q == BLANK_LAST) begin
                state_d = ST_SHOW_L;
                cnt_d   = '0;
            end
            ST_SHOW_L: if (cnt_q == SHOW_LAST) begin
                state_d = ST_BLANK_LR;
                cnt_d   = '0;
            end
            ST_BLANK_LR: if (cnt_q == BLANK_LAST) begin
                state_d = ST_SHOW_R;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_SHOW_R;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SHOW_R;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Blank states pre-select the upcoming digit so the decoder settles dark.
    always_comb begin
        an_n      = 2'b11;
        digit_sel = newest;
        case (state_q)
            ST_SHOW_R: begin
                an_n      = hv[0] ? 2'b10 : 2'b11;
                digit_sel = newest;
            end
            ST_BLANK_RL: digit_sel = older;
            ST_SHOW_L: begin
                an_n      = hv[1] ? 2'b01 : 2'b11;
                digit_sel = older;
            end
            ST_BLANK_LR: digit_sel = newest;
            default: begin
                an_n      = 2'b11;
                digit_sel = newest;
            end
        endcase
    end

    assign hist_valid = hv;

endmodule

// File: tb/tb_display_mux_ctrl.sv
// Scoreboard bench for display_mux_ctrl with short refresh parameters.
module tb_display_mux_ctrl;

    localparam int P   = 8;
    localparam int B   = 2;
    localparam int PER = 2 * (P + B);

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_code;
    logic       key_valid;
    logic       clear;
    logic [3:0] digit_sel;
    logic [1:0] an_n;
    logic [1:0] hist_valid;

    int checks = 0;
    int errors = 0;

    int         phase;
    logic [3:0] m_new, m_old;
    logic [1:0] m_hv;
    logic [7:0] sb[$];

    display_mux_ctrl #(.MUX_PERIOD(P), .BLANK_CYCLES(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .clear      (clear),
        .digit_sel  (digit_sel),
        .an_n       (an_n),
        .hist_valid (hist_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected {hist_valid, an_n, digit_sel} from elapsed-phase view.
    function automatic logic [7:0] expv();
        logic [1:0] an;
        logic [3:0] ds;
        if (phase < P) begin
            an = m_hv[0] ? 2'b10 : 2'b11;
            ds = m_new;
        end else if (phase < P + B) begin
            an = 2'b11;
            ds = m_old;
        end else if (phase < 2 * P + B) begin
            an = m_hv[1] ? 2'b01 : 2'b11;
            ds = m_old;
        end else begin
            an = 2'b11;
            ds = m_new;
        end
        return {m_hv, an, ds};
    endfunction

    task automatic pop_cmp(input string tag);
        logic [7:0] e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk(tag, {24'h0, hist_valid, an_n, digit_sel}, {24'h0, e});
            chk({tag, "_no_both"}, {31'h0, an_n == 2'b00}, 32'd0);
        end
    endtask

    task automatic model_reset();
        phase = 0;
        m_new = 4'h0;
        m_old = 4'h0;
        m_hv  = 2'b00;
    endtask

    task automatic step(input string tag, input logic kv,
                        input logic [3:0] kc, input logic clr);
        key_valid = kv;
        key_code  = kc;
        clear     = clr;
        @(posedge clk);
        phase = (phase == PER - 1) ? 0 : phase + 1;
        if (clr) begin
            m_new = 4'h0;
            m_old = 4'h0;
            m_hv  = 2'b00;
        end else if (kv) begin
            m_old = m_new;
            m_new = kc;
            m_hv  = {m_hv[0], 1'b1};
        end
        sb.push_back(expv());
        @(negedge clk);
        key_valid = 1'b0;
        clear     = 1'b0;
        pop_cmp(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        key_code  = 4'h0;
        key_valid = 1'b0;
        clear     = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        sb.push_back({2'b00, 2'b11, 4'h0});
        pop_cmp("in_reset");

        rst = 1'b0;
        #1;
        sb.push_back(expv());
        pop_cmp("release");
        idle("idle", 40);

        step("key5", 1'b1, 4'h5, 1'b0);
        idle("show5", 40);

        step("key3", 1'b1, 4'h3, 1'b0);
        step("keyC", 1'b1, 4'hC, 1'b0);
        idle("show3C", 40);

        step("clr_key9", 1'b1, 4'h9, 1'b1);
        idle("cleared", 20);

        step("keyA", 1'b1, 4'hA, 1'b0);
        step("keyB", 1'b1, 4'hB, 1'b0);
        idle("refresh5", 5 * PER);

        for (int i = 0; i < 2 * PER && phase != P + B + 4; i++)
            step("to_showl", 1'b0, 4'h0, 1'b0);
        chk("reach_showl5", phase, P + B + 4);

        rst = 1'b1;
        #1;
        model_reset();
        sb.push_back({2'b00, 2'b11, 4'h0});
        pop_cmp("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        sb.push_back(expv());
        pop_cmp("rst_release");
        step("keyD", 1'b1, 4'hD, 1'b0);
        idle("post_rst", 30);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
